// File: rtl/sign_acc_if.sv
// sign_acc_if: beat-in / result-out handshake bundle for sign_acc_block.
// master = producer of beats and consumer of results; slave = the block.
interface sign_acc_if #(
  parameter int CH = 4,
  parameter int IW = 13,
  parameter int OW = 18
);
  logic               in_valid;
  logic               in_ready;
  logic [CH*IW-1:0]   in_data;
  logic [CH-1:0]      in_sign;
  logic               out_valid;
  logic               out_ready;
  logic [CH*OW-1:0]   out_data;
  logic [CH-1:0]      out_sat;

  modport master (
    output in_valid, in_data, in_sign, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_sign, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/sign_acc_block.sv
// sign_acc_block: CH-lane conditional-negate dot-product accumulator.
// Each lane sign-extends its IW-bit beat to the accumulator width, negates it
// when its sign bit is set, and sums M accepted beats. The CH sums are then
// held behind a valid/ready handshake until the consumer takes them.
// Optional build macro SMAC_SAT_EN: clamp each sum to the OW-bit signed range
// and raise out_sat for clamped lanes; otherwise sums are truncated to OW bits.
module sign_acc_block #(
  parameter int M  = 16,
  parameter int Pa = 8,
  parameter int CH = 4,
  parameter int OW = 2 * $clog2(M) + Pa + 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr,
  sign_acc_if.slave bus
);

  localparam int IW = $clog2(M) + Pa + 1;
  localparam int AW = IW + $clog2(M) + 1;
  localparam int CW = $clog2(M + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         count;
  logic signed [AW-1:0]  acc     [CH];
  logic signed [AW-1:0]  ext     [CH];
  logic signed [AW-1:0]  term    [CH];
  logic signed [AW-1:0]  sum_nxt [CH];
  logic [CH*OW-1:0]      data_conv;
  logic [CH*OW-1:0]      out_data_q;
  logic                  accept;
  logic                  last_beat;

`ifdef SMAC_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  logic [CH-1:0]         sat_conv;
  logic [CH-1:0]         out_sat_q;
`endif

  // Handshake: no look-ahead, a held result blocks all input.
  assign bus.in_ready  = (state != HOLD);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = out_data_q;
  assign accept        = bus.in_valid & bus.in_ready;
  assign last_beat     = accept && (count == CW'(M - 1));

`ifdef SMAC_SAT_EN
  assign bus.out_sat = out_sat_q;
`else
  assign bus.out_sat = '0;
`endif

  // Per-lane term: sign-extend first so negating the most negative input is exact.
  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so no latch can be inferred.
    for (int k = 0; k < CH; k++) begin
      ext[k]     = AW'($signed(bus.in_data[k*IW +: IW]));
      term[k]    = bus.in_sign[k] ? -ext[k] : ext[k];
      sum_nxt[k] = (state == IDLE) ? term[k] : acc[k] + term[k];
    end
  end

  // Output conversion of the sum that completes the result (clamp or truncate).
  always_comb begin
    data_conv = '0;
`ifdef SMAC_SAT_EN
    sat_conv  = '0;
`endif
    for (int k = 0; k < CH; k++) begin
`ifdef SMAC_SAT_EN
      if (sum_nxt[k] > SAT_MAX) begin
        data_conv[k*OW +: OW] = SAT_MAX[OW-1:0];
        sat_conv[k]           = 1'b1;
      end else if (sum_nxt[k] < SAT_MIN) begin
        data_conv[k*OW +: OW] = SAT_MIN[OW-1:0];
        sat_conv[k]           = 1'b1;
      end else begin
        data_conv[k*OW +: OW] = sum_nxt[k][OW-1:0];
      end
`else
      data_conv[k*OW +: OW] = sum_nxt[k][OW-1:0];
`endif
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: clr aborts from anywhere, M-th beat enters HOLD.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state_nxt = last_beat ? HOLD : ACC;
        ACC:     if (last_beat) state_nxt = HOLD;
        HOLD:    if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: accumulate accepted beats, capture converted sums on HOLD entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the lane accumulators are a handful of flops, not a RAM, so they are reset with everything else.
      acc        <= '{default: '0};
      count      <= '0;
      out_data_q <= '0;
`ifdef SMAC_SAT_EN
      out_sat_q  <= '0;
`endif
    end else if (clr) begin
      acc       <= '{default: '0};
      count     <= '0;
`ifdef SMAC_SAT_EN
      out_sat_q <= '0;
`endif
    end else if (state == HOLD) begin
      if (bus.out_ready) begin
        acc       <= '{default: '0};
        count     <= '0;
`ifdef SMAC_SAT_EN
        out_sat_q <= '0;
`endif
      end
    end else if (accept) begin
      acc   <= sum_nxt;
      count <= count + CW'(1);
      if (last_beat) begin
        out_data_q <= data_conv;
`ifdef SMAC_SAT_EN
        out_sat_q  <= sat_conv;
`endif
      end
    end
  end

endmodule

// File: doc/sign_acc_block.md
Name: sign_acc_block

Overview:
- Multi-channel, parametrised successor to the single-lane conditional-negate register.
- Each of CH lanes takes a signed partial product and a per-lane sign bit, and conditionally negates the value.
- Each lane accumulates M accepted beats into a dot-product sum, then presents all CH sums through a valid/ready output handshake.
- Sits between the SMAC partial-product array and the output writeback.

Parameters:
M, 16, beats accumulated per result (M >= 1)
Pa, 8, partial-product precision; input width IW = $clog2(M)+Pa+1
CH, 4, number of parallel lanes
OW, IW+$clog2(M)+1, output width per lane; must satisfy OW <= AW, where AW = IW+$clog2(M)+1 (internal accumulator width)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
clr  in  1  synchronous abort/clear
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  CH*IW  lane k at bits [k*IW +: IW], two's complement
in_sign  in  CH  lane k negates its term when 1 (replaces MSB_w)
out_valid  out  1  results available
out_ready  in  1  consumer accepts results
out_data  out  CH*OW  lane k sum at bits [k*OW +: OW]
out_sat  out  CH  per-lane saturation flag (0 unless SAT_EN)

Behaviour:
- Reset (async, rst_n low): state IDLE, count=0, all accumulators=0, out_data=0, out_valid=0, out_sat=0. in_ready=1 after reset release.
- Accept: a beat is accepted when in_valid & in_ready.
- in_ready = (state != HOLD). The block does not look ahead: no acceptance in the cycle out_ready completes.
- Term: each lane sign-extends in_data to AW bits before negation, so -(-2^(IW-1)) is exact (no wrap, unlike the old block).
  - term = in_sign ? -x : x.
- States:
  - IDLE: count=0, accumulators zero. On accept: acc<=term, count<=1; go to ACC (or to HOLD if M==1).
  - ACC: on accept: acc<=acc+term, count<=count+1. When the accepted beat is the M-th, go to HOLD. No accept means hold state.
  - HOLD: out_valid=1; out_data/out_sat are stable and registered on entry. On out_ready: out_valid<=0, accumulators<=0, count<=0, go to IDLE.
- Latency: out_valid rises the cycle after the M-th accept. Gaps in in_valid are permitted and do not alter the result.
- Output conversion:
  - Without SAT_EN: out_data lane = acc[OW-1:0] (two's-complement wrap if OW<AW).
  - With SAT_EN: clamp to the OW-bit signed range.
- clr (sync, highest priority after reset), in any state:
  - accumulators=0, count=0, state IDLE, out_valid<=0, out_sat<=0, out_data retains its last value.
  - Any beat presented that cycle is discarded. in_ready is 1 the cycle after.
- Reset mid-operation: all state drops immediately to reset values; no partial result is emitted.
- count width: $clog2(M+1) bits; never exceeds M.

Optional Feature:
SMAC_SAT_EN
- Defined: on HOLD entry, each lane sum outside [-2^(OW-1), 2^(OW-1)-1] is clamped to the nearest bound. out_sat[k]=1 while that result is held.
- Undefined: truncation to OW bits, out_sat tied to 0, no comparator logic instantiated.
- With OW=AW the two builds give identical out_data.

Test Plan:
All scenarios use M=4, Pa=4, CH=2 (IW=7, AW=10), OW=10 unless stated.
1. Assert rst_n=0 mid-stream -> out_valid=0, out_data=0, out_sat=0, in_ready=1 after release.
2. Lane0 inputs 3,5,7,9 with signs 0,1,0,1; lane1 inputs 10×4 with signs 0; back-to-back -> out_valid the cycle after beat 4; lane0=10'h3FC (-4), lane1=10'd40.
3. Same stimulus with in_valid gaps of 2 cycles, then out_ready low 3 cycles -> identical result; out_valid, out_data held; in_ready=0; extra in_valid beats ignored.
4. Lane0 input 7'h40 (-64), sign=1, four beats -> lane0=+256, out_sat=0.
   - With OW=9 and SMAC_SAT_EN -> lane0=9'h0FF (255), out_sat[0]=1.
   - With OW=9 without SMAC_SAT_EN -> lane0=9'h100 (-256).
5. Two beats accepted, then clr=1 with in_valid=1 -> beat discarded, state IDLE; next four beats 1,1,1,1 with sign 0 -> lane0=4, not 4+prior.
6. M=1 build: single accept of 5 with sign=1 -> out_valid next cycle, lane0=-5; out_ready=1 -> in_ready returns one cycle later.
